regfile_wb_arbiter: RTL and testbench

//  Write-side initiator for the 32x32 register file: owns the single write port (RegWrite/Write_Register/Write_data).

---
 rtl/regfile_wb_arbiter_if.sv | 22 ++
 rtl/regfile_wb_arbiter.sv | 116 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Multi-cycle unit result handshake toward the regfile write arbiter.
// The master side drives results; the slave side returns lu_ready.
interface regfile_wb_arbiter_if;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;

    modport master (
        output lu_valid,
        output lu_rd,
        output lu_data,
        input  lu_ready
    );

    modport slave (
        input  lu_valid,
        input  lu_rd,
        input  lu_data,
        output lu_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: WB stage beats multi-cycle results,
// which queue in a small FIFO; tracks pending multi-cycle writes.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pipe_we,
    input  logic [4:0]          pipe_rd,
    input  logic [31:0]         pipe_data,
    regfile_wb_arbiter_if.slave lu,
    input  logic                issue_set,
    input  logic [4:0]          issue_rd,
    input  logic [4:0]          chk_rs,
    input  logic [4:0]          chk_rt,
    output logic                rs_busy,
    output logic                rt_busy,
    output logic                RegWrite,
    output logic [4:0]          Write_Register,
    output logic [31:0]         Write_data,
    output logic [CW-1:0]       fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [4:0]    rd_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   pending;

    logic pipe_req;
    logic fifo_ne;
    logic accept;
    logic pop;
    logic bypass;
    logic push;

    assign lu.lu_ready = (fifo_count != FULL);
    assign rs_busy     = pending[chk_rs];
    assign rt_busy     = pending[chk_rt];

    // Arbitration: pipe first, then FIFO head, then lu bypass.
    always_comb begin
        pipe_req = pipe_we && (pipe_rd != 5'd0);
        fifo_ne  = (fifo_count != '0);
        accept   = lu.lu_valid && lu.lu_ready;
        pop      = !pipe_req && fifo_ne;
        bypass   = !pipe_req && !fifo_ne && accept && (lu.lu_rd != 5'd0);
        push     = accept && (lu.lu_rd != 5'd0) && !bypass;
    end

    // FIFO storage needs no reset; only pointers and count do.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr]   <= lu.lu_rd;
            data_q[wr_ptr] <= lu.lu_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
        end
    end

    // Registered write port; address/data hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite       <= 1'b0;
            Write_Register <= 5'd0;
            Write_data     <= 32'd0;
        end else begin
            RegWrite <= pipe_req || pop || bypass;
            if (pipe_req) begin
                Write_Register <= pipe_rd;
                Write_data     <= pipe_data;
            end else if (pop) begin
                Write_Register <= rd_q[rd_ptr];
                Write_data     <= data_q[rd_ptr];
            end else if (bypass) begin
                Write_Register <= lu.lu_rd;
                Write_data     <= lu.lu_data;
            end
        end
    end

    // Pending scoreboard: clear on multi-cycle drive, set on issue (set wins).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (pop)
                pending[rd_q[rd_ptr]] <= 1'b0;
            else if (bypass)
                pending[lu.lu_rd] <= 1'b0;
            if (issue_set && (issue_rd != 5'd0))
                pending[issue_rd] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, bypass, FIFO fill
// and drain order, r0 handling and the pending scoreboard.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        issue_set;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_rs;
    logic [4:0]  chk_rt;
    logic        rs_busy;
    logic        rt_busy;
    logic        RegWrite;
    logic [4:0]  Write_Register;
    logic [31:0] Write_data;
    logic [2:0]  fifo_count;

    int checks;
    int failures;

    regfile_wb_arbiter_if lu_if ();

    regfile_wb_arbiter #(.DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .pipe_we        (pipe_we),
        .pipe_rd        (pipe_rd),
        .pipe_data      (pipe_data),
        .lu             (lu_if.slave),
        .issue_set      (issue_set),
        .issue_rd       (issue_rd),
        .chk_rs         (chk_rs),
        .chk_rt         (chk_rt),
        .rs_busy        (rs_busy),
        .rt_busy        (rt_busy),
        .RegWrite       (RegWrite),
        .Write_Register (Write_Register),
        .Write_data     (Write_data),
        .fifo_count     (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        pipe_we        = 1'b0;
        pipe_rd        = 5'd0;
        pipe_data      = 32'd0;
        lu_if.lu_valid = 1'b0;
        lu_if.lu_rd    = 5'd0;
        lu_if.lu_data  = 32'd0;
        issue_set      = 1'b0;
        issue_rd       = 5'd0;
        chk_rs         = 5'd0;
        chk_rt         = 5'd0;

        step();
        check("rst_regwrite", 32'(RegWrite), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_lu_ready", 32'(lu_if.lu_ready), 32'd1);
        reset = 1'b0;
        step();

        // Fill three entries behind pipe writes, with r8 pending.
        issue_set = 1'b1;
        issue_rd  = 5'd8;
        pipe_we   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pipe_rd        = 5'(k + 1);
            pipe_data      = 32'(k + 1);
            lu_if.lu_valid = 1'b1;
            lu_if.lu_rd    = 5'(8 + k);
            lu_if.lu_data  = 32'h100 + 32'(8 + k);
            step();
            issue_set = 1'b0;
        end
        pipe_we        = 1'b0;
        lu_if.lu_valid = 1'b0;
        chk_rs         = 5'd8;
        #1;
        check("fill3_count", 32'(fifo_count), 32'd3);
        check("fill3_pend8", 32'(rs_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_regwrite", 32'(RegWrite), 32'd0);
        check("mid_rst_pend8", 32'(rs_busy), 32'd0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_lu_ready", 32'(lu_if.lu_ready), 32'd1);
        check("post_rst_no_write", 32'(RegWrite), 32'd0);

        // Idle port: lu result bypasses straight to the regfile.
        issue_set = 1'b1;
        issue_rd  = 5'd5;
        step();
        issue_set = 1'b0;
        chk_rs    = 5'd5;
        #1;
        check("pend5_set", 32'(rs_busy), 32'd1);
        lu_if.lu_valid = 1'b1;
        lu_if.lu_rd    = 5'd5;
        lu_if.lu_data  = 32'hDEADBEEF;
        step();
        lu_if.lu_valid = 1'b0;
        check("byp_regwrite", 32'(RegWrite), 32'd1);
        check("byp_wr", 32'(Write_Register), 32'd5);
        check("byp_wd", Write_data, 32'hDEADBEEF);
        check("byp_count", 32'(fifo_count), 32'd0);
        check("byp_pend5_clr", 32'(rs_busy), 32'd0);

        // Pipe every cycle while lu pushes r8..r11 until full.
        pipe_we = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pipe_rd        = 5'(k + 1);
            pipe_data      = 32'hA0 + 32'(k);
            lu_if.lu_valid = 1'b1;
            lu_if.lu_rd    = 5'(8 + k);
            lu_if.lu_data  = 32'h100 + 32'(8 + k);
            step();
        end
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_lu_ready", 32'(lu_if.lu_ready), 32'd0);
        check("full_pipe_wr", 32'(Write_Register), 32'd4);
        check("full_pipe_wd", Write_data, 32'hA3);
        pipe_rd        = 5'd5;
        pipe_data      = 32'hA4;
        lu_if.lu_rd    = 5'd12;
        lu_if.lu_data  = 32'h10C;
        step();
        check("full_hold_count", 32'(fifo_count), 32'd4);
        check("full_pipe_wr2", 32'(Write_Register), 32'd5);

        // Pipe stops: drain in order; pop does not open lu_ready this edge.
        pipe_we = 1'b0;
        step();
        lu_if.lu_valid = 1'b0;
        check("drain0_wr", 32'(Write_Register), 32'd8);
        check("drain0_wd", Write_data, 32'h108);
        check("drain0_count", 32'(fifo_count), 32'd3);
        for (int k = 1; k < 4; k++) begin
            step();
            check("drain_regwrite", 32'(RegWrite), 32'd1);
            check("drain_wr", 32'(Write_Register), 32'(8 + k));
            check("drain_wd", Write_data, 32'h100 + 32'(8 + k));
        end
        check("drained_count", 32'(fifo_count), 32'd0);
        step();
        check("drained_idle", 32'(RegWrite), 32'd0);
        check("drained_hold_wr", 32'(Write_Register), 32'd11);

        // Pipe to r0 is no request: lu r7 bypasses.
        pipe_we        = 1'b1;
        pipe_rd        = 5'd0;
        pipe_data      = 32'h77;
        lu_if.lu_valid = 1'b1;
        lu_if.lu_rd    = 5'd7;
        lu_if.lu_data  = 32'h7777;
        step();
        pipe_we        = 1'b0;
        lu_if.lu_valid = 1'b0;
        check("r0pipe_regwrite", 32'(RegWrite), 32'd1);
        check("r0pipe_wr", 32'(Write_Register), 32'd7);
        check("r0pipe_wd", Write_data, 32'h7777);
        check("r0pipe_count", 32'(fifo_count), 32'd0);

        // Scoreboard on r12: pipe write leaves it, set beats clear.
        issue_set = 1'b1;
        issue_rd  = 5'd12;
        chk_rs    = 5'd12;
        chk_rt    = 5'd12;
        step();
        issue_set = 1'b0;
        check("pend12_rs", 32'(rs_busy), 32'd1);
        check("pend12_rt", 32'(rt_busy), 32'd1);
        pipe_we   = 1'b1;
        pipe_rd   = 5'd12;
        pipe_data = 32'h12;
        step();
        pipe_we = 1'b0;
        check("pend12_pipe_keep", 32'(rs_busy), 32'd1);
        issue_set      = 1'b1;
        lu_if.lu_valid = 1'b1;
        lu_if.lu_rd    = 5'd12;
        lu_if.lu_data  = 32'hC12;
        step();
        issue_set = 1'b0;
        check("pend12_set_wins", 32'(rs_busy), 32'd1);
        check("pend12_wd", Write_data, 32'hC12);
        lu_if.lu_data = 32'hC13;
        step();
        lu_if.lu_valid = 1'b0;
        check("pend12_clr", 32'(rs_busy), 32'd0);
        check("pend12_clr_rt", 32'(rt_busy), 32'd0);

        // lu to r0 is consumed silently; issue to r0 never pends.
        lu_if.lu_valid = 1'b1;
        lu_if.lu_rd    = 5'd0;
        lu_if.lu_data  = 32'hBAD;
        issue_set      = 1'b1;
        issue_rd       = 5'd0;
        chk_rs         = 5'd0;
        step();
        lu_if.lu_valid = 1'b0;
        issue_set      = 1'b0;
        check("lu_r0_regwrite", 32'(RegWrite), 32'd0);
        check("lu_r0_count", 32'(fifo_count), 32'd0);
        check("lu_r0_hold_wd", Write_data, 32'hC13);
        check("r0_busy", 32'(rs_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
